// File: rtl/fir_pkg.sv
// fir_pkg: shared defaults, stream state encoding and ring-address helper for fir_circmem_mc
package fir_pkg;
  localparam int DWIDTH_DEF = 16;
  localparam int AWIDTH_DEF = 6;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;
  // the newest sample sits one slot behind the write pointer
  function automatic int unsigned age_addr(input int unsigned wp, input int unsigned age, input int unsigned aw);
    return (wp - 32'd1 - age) & ((32'd1 << aw) - 32'd1);
  endfunction
endpackage

// File: rtl/fir_circmem_mc_if.sv
// fir_circmem_mc_if: sample input and tap-stream output handshakes of the circular buffer
interface fir_circmem_mc_if import fir_pkg::*; #(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int NCH = 2
);
  localparam int CH_W = NCH > 1 ? $clog2(NCH) : 1;
  logic in_valid;
  logic in_ready;
  logic [CH_W-1:0] in_ch;
  logic [DWIDTH-1:0] in_data;
  logic sym_en;
  logic out_valid;
  logic out_ready;
  logic [DWIDTH-1:0] out_data_a;
  logic [DWIDTH-1:0] out_data_b;
  logic [AWIDTH-1:0] out_tap;
  logic [CH_W-1:0] out_ch;
  logic out_last;
  modport master (
    output in_valid, in_ch, in_data, sym_en, out_ready,
    input in_ready, out_valid, out_data_a, out_data_b, out_tap, out_ch, out_last
  );
  modport slave (
    input in_valid, in_ch, in_data, sym_en, out_ready,
    output in_ready, out_valid, out_data_a, out_data_b, out_tap, out_ch, out_last
  );
endinterface

// File: rtl/fir_tap_seq.sv
// fir_tap_seq: tap counter, beat-count end detection and output-register advance/stall control
module fir_tap_seq #(
  parameter int AWIDTH = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic start,
  input  logic active,
  input  logic sym,
  input  logic out_valid,
  input  logic out_ready,
  input  logic out_last,
  output logic load,
  output logic last_k,
  output logic [AWIDTH-1:0] k
);
  localparam int DEPTH = 2 ** AWIDTH;
  logic [AWIDTH-1:0] count_m1;
  assign count_m1 = sym ? AWIDTH'(DEPTH / 2 - 1) : AWIDTH'(DEPTH - 1);
  // once the last beat sits in the output register nothing more is loaded
  assign load = active && (!out_valid || (out_ready && !out_last));
  assign last_k = k == count_m1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) k <= '0;
    else if (flush || start) k <= '0;
    else if (load) k <= k + 1'b1;
endmodule

// File: rtl/fir_circmem_mc.sv
// fir_circmem_mc: per-channel sample rings streaming tap history (optionally folded) to a FIR MAC
module fir_circmem_mc import fir_pkg::*; #(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int NCH = 2
) (
  input logic clk,
  input logic rst_n,
  input logic flush,
  fir_circmem_mc_if.slave bus
);
  localparam int DEPTH = 2 ** AWIDTH;
  localparam int CH_W = NCH > 1 ? $clog2(NCH) : 1;
  localparam logic [AWIDTH:0] FULL = (AWIDTH + 1)'(DEPTH);
  logic [DWIDTH-1:0] mem [NCH][DEPTH];
  logic [AWIDTH-1:0] wptr [NCH];
  logic [AWIDTH:0] fill [NCH];
  logic [0:0] state;
  logic [CH_W-1:0] cur_ch;
  logic cur_sym, cur_ok;
  logic accept, in_ok, load, last_k, done;
  logic [AWIDTH-1:0] k, wp_cur, addr_a, addr_b, age_b;
  logic [AWIDTH:0] fill_cur;
  logic [DWIDTH-1:0] data_a, data_b, out_data_a, out_data_b;
  logic out_valid, out_last;
  logic [AWIDTH-1:0] out_tap;
  logic [CH_W-1:0] out_ch;
  assign bus.in_ready = state == IDLE && !flush;
  assign accept = bus.in_valid && bus.in_ready;
  assign in_ok = 32'(bus.in_ch) < NCH;
  assign done = state == STREAM && out_valid && bus.out_ready && out_last;
  assign wp_cur = cur_ok ? wptr[cur_ch] : '0;
  assign fill_cur = cur_ok ? fill[cur_ch] : '0;
  assign age_b = ~k;
  assign addr_a = AWIDTH'(age_addr(32'(wp_cur), 32'(k), AWIDTH));
  assign addr_b = AWIDTH'(age_addr(32'(wp_cur), 32'(age_b), AWIDTH));
  // ages at or beyond the fill count read as zero history
  assign data_a = cur_ok && {1'b0, k} < fill_cur ? mem[cur_ch][addr_a] : '0;
  assign data_b = cur_sym && cur_ok && {1'b0, age_b} < fill_cur ? mem[cur_ch][addr_b] : '0;
  assign bus.out_valid = out_valid;
  assign bus.out_data_a = out_data_a;
  assign bus.out_data_b = out_data_b;
  assign bus.out_tap = out_tap;
  assign bus.out_ch = out_ch;
  assign bus.out_last = out_last;
  fir_tap_seq #(.AWIDTH(AWIDTH)) u_seq (
    .clk(clk), .rst_n(rst_n), .flush(flush), .start(accept), .active(state == STREAM),
    .sym(cur_sym), .out_valid(out_valid), .out_ready(bus.out_ready), .out_last(out_last),
    .load(load), .last_k(last_k), .k(k)
  );
  always_ff @(posedge clk)
    if (accept && in_ok) mem[bus.in_ch][wptr[bus.in_ch]] <= bus.in_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < NCH; i++) begin
      wptr[i] <= '0;
      fill[i] <= '0;
    end
    else if (flush) for (int i = 0; i < NCH; i++) begin
      wptr[i] <= '0;
      fill[i] <= '0;
    end
    else if (accept && in_ok) begin
      wptr[bus.in_ch] <= wptr[bus.in_ch] + 1'b1;
      fill[bus.in_ch] <= fill[bus.in_ch] == FULL ? FULL : fill[bus.in_ch] + 1'b1;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cur_ch <= '0;
      cur_sym <= 1'b0;
      cur_ok <= 1'b0;
      out_valid <= 1'b0;
      out_data_a <= '0;
      out_data_b <= '0;
      out_tap <= '0;
      out_ch <= '0;
      out_last <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      out_valid <= 1'b0;
      out_last <= 1'b0;
    end else begin
      if (accept) begin
        state <= STREAM;
        cur_ch <= bus.in_ch;
        cur_sym <= bus.sym_en;
        cur_ok <= in_ok;
      end
      if (load) begin
        out_valid <= 1'b1;
        out_data_a <= data_a;
        out_data_b <= data_b;
        out_tap <= k;
        out_ch <= cur_ch;
        out_last <= last_k;
      end else if (done) begin
        state <= IDLE;
        out_valid <= 1'b0;
        out_last <= 1'b0;
      end
    end
endmodule

// File: tb/tb_fir_circmem_mc.sv
// tb_fir_circmem_mc: random and directed stimulus against a queue-based model of channel history
module tb_fir_circmem_mc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic rnd_ready = 1'b0;
  int n_chk = 0;
  int n_err = 0;
  int n_beats = 0;
  logic [15:0] hist [2][$];
  logic [39:0] exp_q [$];
  fir_circmem_mc_if #(.DWIDTH(16), .AWIDTH(6), .NCH(2)) bus ();
  fir_circmem_mc #(.DWIDTH(16), .AWIDTH(6), .NCH(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus)
  );
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [39:0] pk(input logic [15:0] a, input logic [15:0] b, input int tap, input int ch, input logic last);
    return {a, b, 6'(tap), 1'(ch), last};
  endfunction

  task automatic clear_model();
    hist[0].delete();
    hist[1].delete();
    exp_q.delete();
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_q.size() != 0 || !bus.in_ready) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("stream_end", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic send(input int ch, input logic [15:0] d, input logic s);
    int cnt;
    wait_done();
    bus.in_valid = 1'b1;
    bus.in_ch = 1'(ch);
    bus.in_data = d;
    bus.sym_en = s;
    hist[ch].push_front(d);
    if (hist[ch].size() > 64) void'(hist[ch].pop_back());
    cnt = s ? 32 : 64;
    n_beats = 0;
    for (int k = 0; k < cnt; k++) begin
      logic [15:0] a, b;
      a = k < hist[ch].size() ? hist[ch][k] : 16'h0;
      b = (s && (63 - k) < hist[ch].size()) ? hist[ch][63 - k] : 16'h0;
      exp_q.push_back(pk(a, b, k, ch, k == cnt - 1));
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    chk("lat_n", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    chk("lat_n1", 64'(bus.out_valid), 64'd1);
  endtask

  task automatic wait_beats(input int nb);
    int n = 0;
    while (n_beats < nb && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("beat_wait", 64'(n_beats >= nb), 64'd1);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    clear_model();
    @(negedge clk);
    chk("flush_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_ready", 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 bus.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  logic prev_stall = 1'b0;
  logic last_acc = 1'b0;
  logic [39:0] prev_beat;
  always @(negedge clk) begin
    logic [39:0] cur;
    cur = {bus.out_data_a, bus.out_data_b, bus.out_tap, bus.out_ch, bus.out_last};
    if (last_acc) chk("ready_after_last", 64'(bus.in_ready), 64'd1);
    if (prev_stall) chk("stall_stable", {23'd0, bus.out_valid, cur}, {23'd0, 1'b1, prev_beat});
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) chk("extra_beat", 64'd1, 64'd0);
      else chk("beat", 64'(cur), 64'(exp_q.pop_front()));
      n_beats++;
    end
    last_acc = bus.out_valid && bus.out_ready && bus.out_last;
    prev_stall = bus.out_valid && !bus.out_ready && rst_n && !flush;
    prev_beat = cur;
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_ch = 1'b0;
    bus.in_data = 16'h0;
    bus.sym_en = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_tap", 64'(bus.out_tap), 64'd0);
    chk("rst_out_last", 64'(bus.out_last), 64'd0);
    chk("rst_out_data", {32'd0, bus.out_data_a, bus.out_data_b}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    send(0, 16'h0001, 1'b0);
    for (int i = 1; i <= 70; i++) send(0, 16'(i), 1'b0);
    do_flush();
    for (int i = 0; i < 10; i++) begin
      send(0, 16'(16'h100 + i), 1'b0);
      send(1, 16'(16'h200 + i), 1'b0);
    end
    for (int i = 1; i <= 64; i++) send(0, 16'(i), 1'b0);
    send(0, 16'd65, 1'b1);
    rnd_ready = 1'b1;
    send(1, 16'h1234, 1'b0);
    for (int i = 0; i < 30; i++)
      send(int'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
    wait_done();
    rnd_ready = 1'b0;
    @(negedge clk);
    send(0, 16'h5555, 1'b0);
    wait_beats(10);
    do_flush();
    send(0, 16'hAAAA, 1'b0);
    wait_done();
    send(1, 16'h7777, 1'b0);
    wait_beats(10);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_last", 64'(bus.out_last), 64'd0);
    chk("arst_ready", 64'(bus.in_ready), 64'd1);
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(0, 16'hAAAA, 1'b0);
    wait_done();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
